sec_encoder: RTL and testbench
==============================

# sec_encoder

Pipelined Hamming single-error-correction encoder: the write-side companion of the 32-bit/6-parity SEC decoder. It accepts 32-bit data words over a valid/ready handshake and emits each word with its 6 parity bits from a registered output stage. Its parity equations exactly match the decoder's syndrome equations, so an unaltered codeword decodes with syndrome 0. A one-shot error injector lets benches and built-in self-test flip any single codeword bit before storage.

## Interface
- CNT_W, 16, width of the accepted-word counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  encoder can accept a word this cycle
- in_data  in  32  data word to encode
- out_valid  out  1  codeword valid
- out_ready  in  1  downstream accepts codeword
- out_data  out  32  data part of codeword (possibly injected)
- out_parity  out  6  parity part of codeword (possibly injected)
- inj_arm  in  1  single-cycle pulse that arms the injector
- inj_pos  in  6  codeword bit to flip: 0–31 = data[n], 32–37 = parity[n-32]
- inj_pending  out  1  injector armed, not yet consumed
- word_count  out  CNT_W  number of accepted input words, wraps modulo 2^CNT_W

## Operation
- Parity is the XOR of these data bits:
  - p0: 0,1,3,4,6,8,10,11,13,15,17,19,21,23,25,26,28,30
  - p1: 0,2,3,5,6,9,10,12,13,16,17,20,21,24,25,27,28,31
  - p2: 1,2,3,7,8,9,10,14,15,16,17,22,23,24,25,29,30,31
  - p3: 4–10, 18–25
  - p4: 11–25
  - p5: 26–31
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready (combinational). This is one stage with full throughput and no skid buffer.
- On accept:
  - the output register loads in_data and its computed parity;
  - out_valid is set;
  - word_count increments.
- If out_valid && out_ready and there is no accept that cycle, out_valid clears.
- While out_valid && !out_ready, out_data and out_parity hold stable.
- Injector:
  - inj_arm latches inj_pos into the position register and sets inj_pending.
  - The next accept applies the flip to the loaded codeword, then clears inj_pending.
  - If the latched position is ≥ 38, no bit flips, but inj_pending still clears.
- Arm on the same cycle as an accept: the word accepted that cycle is unaffected. The new arming applies to the following accept.
- Arm while already pending: the position is overwritten and inj_pending stays 1.
- Injection never alters parity computation or word_count.

## Timing
- Latency: 1 cycle. A word accepted at edge N is presented with out_valid=1 after edge N.
- Throughput: 1 word per cycle while out_ready=1.
- Reset (asynchronous assert, synchronous-safe deassert by upstream): out_valid=0, out_data=0, out_parity=0, inj_pending=0, injector position=0, word_count=0.
- Reset mid-transfer drops the held word; no replay.
- word_count wraps from 2^CNT_W−1 to 0 with no flag.

## Structure
- Shared package sec_pkg:
  - DATA_W=32, PAR_W=6, CW_W=38;
  - the six parity bit-mask constants (32-bit masks);
  - a function computing parity from data via the masks.
- The decoder reuses the same masks, keeping both ends consistent by construction.
- One natural sub-module: sec_parity_gen (combinational, data → 6-bit parity), instantiated here and reusable for syndrome generation.

## Test plan
- Reset, then send in_data=0x00000000 with out_ready=1 → next cycle out_valid=1, out_parity=0x00, word_count=1.
- Send 0x00000001, 0xFFFFFFFF, 0x80000000 back-to-back → out_parity 0x03, 0x18, 0x26 on consecutive cycles; in_ready stays 1.
- Hold out_ready=0 with a word valid → in_ready=0, output stable for 5 cycles. Raise out_ready with in_valid=1 → the new word loads on the same edge that the held word leaves.
- Arm inj_pos=5, then send 0x00000000 → out_data=0x00000020, out_parity=0x00, inj_pending 1→0. Arm inj_pos=33, send 0 → out_parity=0x02. Arm inj_pos=40, send 0 → codeword unchanged, inj_pending clears.
- Arm on the same cycle as accepting word A, then send word B → A is clean and B is flipped. Feed all outputs to the SEC decoder → it corrects B and reports syndrome 0 for A.
- Preload word_count to 0xFFFF through 65535 accepts, then accept 1 more → 0x0000. Assert rst_n=0 mid-stall → out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sec_pkg.sv
// Shared definitions for the 32-bit / 6-parity Hamming SEC encoder and decoder.
// The parity masks below are the single source of truth for both ends, so an
// unaltered codeword always decodes with a zero syndrome.
package sec_pkg;

    localparam int DATA_W = 32;
    localparam int PAR_W  = 6;
    localparam int CW_W   = DATA_W + PAR_W;

    // One mask per parity bit: a set bit means that data bit feeds the XOR
    localparam logic [DATA_W-1:0] PAR_MASK_P0 = 32'h56AA_AD5B;
    localparam logic [DATA_W-1:0] PAR_MASK_P1 = 32'h9B33_366D;
    localparam logic [DATA_W-1:0] PAR_MASK_P2 = 32'hE3C3_C78E;
    localparam logic [DATA_W-1:0] PAR_MASK_P3 = 32'h03FC_07F0;
    localparam logic [DATA_W-1:0] PAR_MASK_P4 = 32'h03FF_F800;
    localparam logic [DATA_W-1:0] PAR_MASK_P5 = 32'hFC00_0000;

    // Parity of a data word; reused by the decoder to form the syndrome
    function automatic logic [PAR_W-1:0] calc_parity(input logic [DATA_W-1:0] data);
        logic [PAR_W-1:0] par;
        par[0] = ^(data & PAR_MASK_P0);
        par[1] = ^(data & PAR_MASK_P1);
        par[2] = ^(data & PAR_MASK_P2);
        par[3] = ^(data & PAR_MASK_P3);
        par[4] = ^(data & PAR_MASK_P4);
        par[5] = ^(data & PAR_MASK_P5);
        return par;
    endfunction

endpackage

// File: rtl/sec_parity_gen.sv
// Combinational parity generator: data word in, 6-bit Hamming parity out.
// Also usable on the read side to regenerate parity for syndrome computation.
module sec_parity_gen
    import sec_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [PAR_W-1:0]  parity_o
);

    // Pure XOR-tree evaluation of the shared parity masks
    always_comb begin
        parity_o = calc_parity(data_i);
    end

endmodule

// File: rtl/sec_encoder.sv
// Single-stage pipelined Hamming SEC encoder with valid/ready handshake,
// accepted-word counter and a one-shot single-bit error injector.
module sec_encoder
    import sec_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_parity,
    input  logic              inj_arm,
    input  logic [5:0]        inj_pos,
    output logic              inj_pending,
    output logic [CNT_W-1:0]  word_count
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [PAR_W-1:0]  parity_q;
    logic              pend_q;
    logic [5:0]        pos_q;
    logic [CNT_W-1:0]  count_q;

    logic [PAR_W-1:0]  parity_calc;
    logic [CW_W-1:0]   flip_d;
    logic              accept;

    sec_parity_gen u_parity_gen (
        .data_i   (in_data),
        .parity_o (parity_calc)
    );

    // Single stage with no skid buffer: ready whenever the slot is empty or draining
    always_comb begin
        in_ready = !valid_q || out_ready;
        accept   = in_valid && in_ready;
    end

    // One-hot flip pattern from the armed position; out-of-range positions flip nothing
    always_comb begin
        flip_d = '0;
        if (pend_q && (pos_q < 6'(CW_W))) begin
            flip_d = CW_W'(1) << pos_q;
        end
    end

    // Output register, counter and injector state; injector reads the pre-arm state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            parity_q <= '0;
            pend_q   <= 1'b0;
            pos_q    <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                data_q   <= in_data ^ flip_d[DATA_W-1:0];
                parity_q <= parity_calc ^ flip_d[CW_W-1:DATA_W];
                valid_q  <= 1'b1;
                count_q  <= count_q + 1'b1;
            end else if (out_ready) begin
                valid_q  <= 1'b0;
            end

            if (inj_arm) begin
                pos_q  <= inj_pos;
                pend_q <= 1'b1;
            end else if (accept) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_parity  = parity_q;
    assign inj_pending = pend_q;
    assign word_count  = count_q;

endmodule

// File: tb/tb_sec_encoder.sv
// Directed bench for sec_encoder: a behavioural model pushes expected codewords
// into a queue as words are driven, and a monitor pops them as the DUT emits.
module tb_sec_encoder;

    localparam int CNT_W = 16;

    // Parity membership lists written out bit by bit
    localparam int P0_BITS [18] = '{0,1,3,4,6,8,10,11,13,15,17,19,21,23,25,26,28,30};
    localparam int P1_BITS [18] = '{0,2,3,5,6,9,10,12,13,16,17,20,21,24,25,27,28,31};
    localparam int P2_BITS [18] = '{1,2,3,7,8,9,10,14,15,16,17,22,23,24,25,29,30,31};

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  parity;
    } cw_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [5:0]       out_parity;
    logic             inj_arm;
    logic [5:0]       inj_pos;
    logic             inj_pending;
    logic [CNT_W-1:0] word_count;

    cw_t              expQ[$];
    int               checks = 0;
    int               errors = 0;
    logic             mdlValid = 1'b0;
    logic             mdlPend  = 1'b0;
    logic [5:0]       mdlPos   = '0;
    logic [CNT_W-1:0] mdlCount = '0;
    logic [31:0]      heldWord;

    sec_encoder #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_parity  (out_parity),
        .inj_arm     (inj_arm),
        .inj_pos     (inj_pos),
        .inj_pending (inj_pending),
        .word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference parity built from the explicit bit lists and ranges
    function automatic logic [5:0] refParity(input logic [31:0] d);
        logic [5:0] p;
        p = '0;
        for (int i = 0; i < 18; i++) begin
            p[0] ^= d[P0_BITS[i]];
            p[1] ^= d[P1_BITS[i]];
            p[2] ^= d[P2_BITS[i]];
        end
        for (int i = 4; i <= 10; i++) p[3] ^= d[i];
        for (int i = 18; i <= 25; i++) p[3] ^= d[i];
        for (int i = 11; i <= 25; i++) p[4] ^= d[i];
        for (int i = 26; i <= 31; i++) p[5] ^= d[i];
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, update the model, and advance past the edge
    task automatic applyStimulus(input logic valid, input logic [31:0] data,
                                 input logic arm, input logic [5:0] pos);
        cw_t e;
        in_valid = valid;
        in_data  = data;
        inj_arm  = arm;
        inj_pos  = pos;
        #1;
        checkOutput("in_ready", in_ready, !mdlValid || out_ready);
        if (valid && (!mdlValid || out_ready)) begin
            e.data   = data;
            e.parity = refParity(data);
            if (mdlPend && mdlPos < 6'd38) begin
                if (mdlPos < 6'd32) e.data[mdlPos[4:0]] = ~e.data[mdlPos[4:0]];
                else e.parity[3'(mdlPos - 6'd32)] = ~e.parity[3'(mdlPos - 6'd32)];
            end
            mdlPend = 1'b0;
            expQ.push_back(e);
            mdlCount = mdlCount + 1'b1;
            mdlValid = 1'b1;
        end else if (out_ready) begin
            mdlValid = 1'b0;
        end
        if (arm) begin
            mdlPend = 1'b1;
            mdlPos  = pos;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        inj_arm  = 1'b0;
    endtask

    // Compare each codeword as it is handed off downstream
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_word", 1, 0);
            end else begin
                cw_t e;
                e = expQ.pop_front();
                checkOutput("out_data", out_data, e.data);
                checkOutput("out_parity", out_parity, e.parity);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        inj_arm   = 1'b0;
        inj_pos   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_parity", out_parity, 0);
        checkOutput("rst_inj_pending", inj_pending, 0);
        checkOutput("rst_word_count", word_count, 0);

        applyStimulus(1'b1, 32'h0000_0000, 1'b0, 6'd0);
        checkOutput("first_valid", out_valid, 1);
        checkOutput("first_parity", out_parity, 6'h00);
        checkOutput("first_count", word_count, 1);

        applyStimulus(1'b1, 32'h0000_0001, 1'b0, 6'd0);
        checkOutput("par_0001", out_parity, 6'h03);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 6'd0);
        checkOutput("par_ffff", out_parity, 6'h18);
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, 6'd0);
        checkOutput("par_8000", out_parity, 6'h26);
        applyStimulus(1'b0, 32'h0, 1'b0, 6'd0);
        checkOutput("drained", out_valid, 0);

        out_ready = 1'b0;
        heldWord  = 32'h1234_5678;
        applyStimulus(1'b1, heldWord, 1'b0, 6'd0);
        in_valid = 1'b1;
        in_data  = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_data", out_data, heldWord);
            checkOutput("stall_parity", out_parity, refParity(heldWord));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0, 6'd0);
        checkOutput("release_data", out_data, 32'hCAFE_F00D);

        applyStimulus(1'b0, 32'h0, 1'b1, 6'd5);
        checkOutput("arm5_pending", inj_pending, 1);
        applyStimulus(1'b1, 32'h0, 1'b0, 6'd0);
        checkOutput("inj5_data", out_data, 32'h0000_0020);
        checkOutput("inj5_parity", out_parity, 6'h00);
        checkOutput("inj5_pending", inj_pending, 0);

        applyStimulus(1'b0, 32'h0, 1'b1, 6'd33);
        applyStimulus(1'b1, 32'h0, 1'b0, 6'd0);
        checkOutput("inj33_parity", out_parity, 6'h02);

        applyStimulus(1'b0, 32'h0, 1'b1, 6'd40);
        checkOutput("arm40_pending", inj_pending, 1);
        applyStimulus(1'b1, 32'h0, 1'b0, 6'd0);
        checkOutput("inj40_data", out_data, 32'h0);
        checkOutput("inj40_parity", out_parity, 6'h00);
        checkOutput("inj40_pending", inj_pending, 0);

        applyStimulus(1'b1, 32'hA5A5_0F0F, 1'b1, 6'd7);
        checkOutput("wordA_syndrome", refParity(out_data) ^ out_parity, 6'h00);
        checkOutput("wordA_pending", inj_pending, 1);
        applyStimulus(1'b1, 32'h0BAD_BEEF, 1'b0, 6'd0);
        checkOutput("wordB_data", out_data, 32'h0BAD_BEEF ^ 32'h0000_0080);
        checkOutput("wordB_syndrome", refParity(out_data) ^ out_parity, 6'h0C);

        while (mdlCount != 16'hFFFF) begin
            applyStimulus(1'b1, $urandom, 1'b0, 6'd0);
        end
        checkOutput("count_max", word_count, 16'hFFFF);
        applyStimulus(1'b1, 32'h0F0F_0F0F, 1'b0, 6'd0);
        checkOutput("count_wrap", word_count, 16'h0000);
        applyStimulus(1'b0, 32'h0, 1'b0, 6'd0);

        out_ready = 1'b0;
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 6'd3);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", out_valid, 0);
        checkOutput("async_rst_pending", inj_pending, 0);
        checkOutput("async_rst_count", word_count, 0);
        expQ.delete();
        mdlValid = 1'b0;
        mdlPend  = 1'b0;
        mdlCount = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h0000_0001, 1'b0, 6'd0);
        checkOutput("post_rst_parity", out_parity, 6'h03);
        applyStimulus(1'b0, 32'h0, 1'b0, 6'd0);
        @(posedge clk);
        #1;
        checkOutput("queue_empty", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
